instr_mem_loader: RTL
=====================

// Module: instr_mem_loader
// PURPOSE
//   Parametrised, run-time loadable instruction memory for the 4-register test CPU.
//   Programs arrive as a valid/ready word stream instead of hard-wired constants.
//   The CPU fetch port sees registered reads with 1-cycle latency.
//   Any address past the loaded program length reads as the STOP word, so the CPU halts safely.
// PARAMETERS
//   IW         8                  instruction width in bits
//   DEPTH      32                 number of instruction words
//   AW         $clog2(DEPTH)      fetch address width; DEPTH need not be a power of two
//   STOP_WORD  8'b11000011        word returned for unloaded/out-of-range addresses
// PORTS
//   clk          in   1       single clock; all logic on the rising edge
//   clear_n      in   1       reset, synchronous, active-low
//   load_valid   in   1       load stream: word present on load_data
//   load_ready   out  1       load stream: block accepts a word this cycle
//   load_data    in   IW      program word; words are written from address 0 upward
//   load_last    in   1       qualifies the final word of a program
//   fetch_req    in   1       CPU read request
//   fetch_addr   in   AW      CPU read address
//   fetch_valid  out  1       instruction valid; asserted 1 cycle after fetch_req
//   instruction  out  IW      fetched word
//   prog_len     out  AW+1    number of words in the current committed program
//   loading      out  1       high while in the LOAD state
//   overflow     out  1       sticky flag: a load word was dropped because the memory was full
// BEHAVIOUR
//   Reset (clear_n=0 at an edge)
//     state=IDLE, wr_ptr=0, prog_len=0, overflow=0, fetch_valid=0, instruction=STOP_WORD.
//     Memory contents are not cleared; prog_len=0 hides them.
//     Reset overrides every other input in the same cycle, including mid-LOAD.
//   load_ready = (state==IDLE || state==LOAD); a word is accepted only when load_valid && load_ready.
//   FSM, 2 states
//     IDLE: on an accepted word
//       - write mem[0], wr_ptr<=1, prog_len<=0 (old program retired immediately).
//       - if load_last: prog_len<=1 and stay in IDLE; else go to LOAD.
//     LOAD: on an accepted word
//       - if wr_ptr<DEPTH: write mem[wr_ptr], wr_ptr++.
//       - else: drop the word and set overflow<=1.
//       - if load_last: prog_len<=number of words stored (saturates at DEPTH), then go to IDLE.
//       - No word accepted (load_valid=0) leaves the FSM in LOAD with no change.
//   Fetch: fetch_valid<=fetch_req every cycle, in both states.
//     instruction <= (state==IDLE && fetch_addr<prog_len) ? mem[fetch_addr] : STOP_WORD.
//     During LOAD, and in the same cycle as the first accepted word of a program, fetches return STOP_WORD.
//     Read and write therefore never collide.
//   When fetch_req=0, instruction holds its previous value.
//   overflow clears only on reset; a new load does not clear it.
//   Arithmetic: wr_ptr and prog_len are AW+1 bits wide, so DEPTH itself is representable.
//     The comparison fetch_addr<prog_len is unsigned.
// STRUCTURE
//   Package instr_mem_pkg
//     opcode constants OP_ADD=2'b00, OP_LW=2'b01, OP_STOP=2'b11.
//     field positions op[7:6], rs[5:4], rt[3:2], rd/imm[1:0].
//     default STOP_WORD.
//     FSM state enum {IDLE, LOAD}.
//   One sub-module, instr_mem_array: a single-port-write, single-port-read synchronous RAM
//     (IW x DEPTH, no reset). FSM, pointers and fetch mux stay in the top.
// TESTING
//   T1 reset, then fetch_addr=0 -> next cycle: fetch_valid=1, instruction=8'hC3, prog_len=0, overflow=0.
//   T2 stream 11 words 49,27,39,18,07,32,2D,18,4D,1E,C3 (hex), load_last on the 11th
//      -> prog_len=11; fetch 9 -> 8'h1E; fetch 10 -> 8'hC3; fetch 20 -> 8'hC3.
//   T3 repeat T2 with load_valid deasserted for 1-3 cycles between words
//      -> identical contents; loading=1 throughout the transfer; fetch 3 during LOAD -> 8'hC3.
//   T4 DEPTH=32: stream 34 words 8'h00..8'h21, last on word 34
//      -> prog_len=32, overflow=1, fetch 31 -> 8'h1F.
//   T5 after T4, load the 3 words 8'h49,8'h27,8'hC3
//      -> prog_len=3; fetch 1 -> 8'h27; fetch 5 -> 8'hC3 (stale data hidden); overflow stays 1.
//   T6 clear_n=0 for one cycle after 4 words of a load
//      -> prog_len=0, loading=0, overflow=0; fetch 0 -> 8'hC3; a fresh load then starts at address 0.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Package instr_mem_pkg: shared definitions for the loadable instruction memory
// of the 4-register test CPU.
//   - opcode constants and instruction field positions
//   - default STOP word returned for unloaded / out-of-range fetches
//   - loader FSM state encoding
package instr_mem_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_LW   = 2'b01;
  localparam logic [1:0] OP_STOP = 2'b11;

  // Field positions: op[7:6], rs[5:4], rt[3:2], rd/imm[1:0]
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 6;
  localparam int RS_MSB = 5;
  localparam int RS_LSB = 4;
  localparam int RT_MSB = 3;
  localparam int RT_LSB = 2;
  localparam int RD_MSB = 1;
  localparam int RD_LSB = 0;

  localparam logic [7:0] STOP_WORD_DEF = 8'b11000011;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  function automatic logic [1:0] instr_op(input logic [7:0] w);
    return w[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Interface instr_mem_loader_if: load stream and CPU fetch port of the
// instruction memory loader.
//   load_valid/load_ready/load_data/load_last : program word stream
//   fetch_req/fetch_addr                      : CPU read request
//   fetch_valid/instruction                   : registered read response
// Modports: master = stream producer / CPU side, slave = memory loader.
interface instr_mem_loader_if #(
  parameter int IW = 8,
  parameter int AW = 5
);
  logic          load_valid;
  logic          load_ready;
  logic [IW-1:0] load_data;
  logic          load_last;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_valid;
  logic [IW-1:0] instruction;

  modport master (
    output load_valid, load_data, load_last, fetch_req, fetch_addr,
    input  load_ready, fetch_valid, instruction
  );

  modport slave (
    input  load_valid, load_data, load_last, fetch_req, fetch_addr,
    output load_ready, fetch_valid, instruction
  );
endinterface

// File: rtl/instr_mem_loader_array.sv
// Module instr_mem_array: IW x DEPTH synchronous RAM, one write port and one
// registered read port, no reset on the storage or read register.
//   clk   : clock
//   we    : write enable, waddr/wdata : write port
//   re    : read enable,  raddr       : read address
//   rdata : read data, updated one cycle after re, held otherwise
module instr_mem_array #(
  parameter int IW    = 8,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Module instr_mem_loader: run-time loadable instruction memory.
// Programs stream in over load_valid/load_ready (from address 0 upward,
// load_last marks the final word). The CPU fetch port returns a registered
// word one cycle after fetch_req; addresses at or beyond the committed
// program length, and any fetch while a load is in progress, read STOP_WORD.
//   clk, clear_n : clock, synchronous active-low reset
//   bus          : load stream + fetch port (slave modport)
//   prog_len     : committed program length (AW+1 bits, can equal DEPTH)
//   loading      : high in the LOAD state
//   overflow     : sticky, a word was dropped because memory was full
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int            IW        = 8,
  parameter int            DEPTH     = 32,
  parameter int            AW        = $clog2(DEPTH),
  parameter logic [IW-1:0] STOP_WORD = IW'(STOP_WORD_DEF)
) (
  input  logic                clk,
  input  logic                clear_n,
  instr_mem_loader_if.slave   bus,
  output logic [AW:0]         prog_len,
  output logic                loading,
  output logic                overflow
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state, state_nxt;
  logic [AW:0]   wr_ptr, wr_ptr_nxt;
  logic [AW:0]   prog_len_nxt;
  logic          overflow_nxt;
  logic          accept;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          rd_hit;
  logic          hit_p1;
  logic [IW-1:0] rd_data_p1;

  assign bus.load_ready = (state == IDLE) || (state == LOAD);
  assign accept         = bus.load_valid && bus.load_ready;
  assign loading        = (state == LOAD);

  // A fetch may use the RAM only for a committed program; the first word of a
  // new load retires the old program in the same cycle, so it is excluded too.
  // This also guarantees the read and write ports never touch the RAM together.
  assign rd_hit = (state == IDLE) && !accept && ({1'b0, bus.fetch_addr} < prog_len);

  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    prog_len_nxt = prog_len;
    overflow_nxt = overflow;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          mem_we       = 1'b1;
          mem_waddr    = '0;
          wr_ptr_nxt   = (AW+1)'(1);
          prog_len_nxt = '0;
          if (bus.load_last) prog_len_nxt = (AW+1)'(1);
          else               state_nxt    = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          if (wr_ptr < DEPTH_W) begin
            mem_we     = 1'b1;
            mem_waddr  = wr_ptr[AW-1:0];
            wr_ptr_nxt = wr_ptr + 1'b1;
          end else begin
            overflow_nxt = 1'b1;
          end
          if (bus.load_last) begin
            // wr_ptr never exceeds DEPTH, so this saturates the length at DEPTH
            prog_len_nxt = (wr_ptr < DEPTH_W) ? wr_ptr + 1'b1 : DEPTH_W;
            state_nxt    = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      prog_len        <= '0;
      overflow        <= 1'b0;
      bus.fetch_valid <= 1'b0;
      hit_p1          <= 1'b0;
    end else begin
      state           <= state_nxt;
      wr_ptr          <= wr_ptr_nxt;
      prog_len        <= prog_len_nxt;
      overflow        <= overflow_nxt;
      bus.fetch_valid <= bus.fetch_req;
      if (bus.fetch_req) hit_p1 <= rd_hit;
    end
  end

  instr_mem_array #(
    .IW    (IW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we && clear_n),
    .waddr (mem_waddr),
    .wdata (bus.load_data),
    .re    (bus.fetch_req && rd_hit && clear_n),
    .raddr (bus.fetch_addr),
    .rdata (rd_data_p1)
  );

  // ---- read stage p1: select RAM word or STOP_WORD ----
  // hit_p1 and the RAM read register only update on fetch_req, so the
  // instruction holds between fetches; reset clears hit_p1 to force STOP_WORD.
  assign bus.instruction = hit_p1 ? rd_data_p1 : STOP_WORD;

endmodule
